// File: rtl/us_cmd_sched.sv
// Upstream command scheduler: pops commands from a FWFT FIFO and turns each one
// into a completion request, a train of MWr32 TLP requests, or a bad-command pulse.

`ifndef US_CMD_CPL_TYPE
`define US_CMD_CPL_TYPE 2'b00
`endif
`ifndef US_CMD_CPLD_TYPE
`define US_CMD_CPLD_TYPE 2'b01
`endif
`ifndef US_CMD_WR32_TYPE
`define US_CMD_WR32_TYPE 2'b10
`endif

module us_cmd_sched #(
  parameter int unsigned MAX_PAYLOAD_DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [127:0]  us_cmd_fifo_dout_i,
  input  logic          us_cmd_fifo_empty_i,
  output logic          us_cmd_fifo_rd_en_o,
  output logic          cpl_req_o,
  output logic          cpl_with_data_o,
  output logic [54:0]   cpl_fields_o,
  input  logic          cpl_ack_i,
  output logic          wr_req_o,
  output logic [31:0]   wr_addr_o,
  output logic [9:0]    wr_len_dw_o,
  input  logic          wr_ack_i,
  output logic          up_wr_cmd_compl_o,
  output logic [1:0]    cmd_id_o,
  output logic          bad_cmd_o,
  output logic          busy_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_CPL     = 3'd2;
  localparam logic [2:0] S_WR      = 3'd3;
  localparam logic [2:0] S_WR_NEXT = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [9:0] MAX_DW = 10'(MAX_PAYLOAD_DW);

  // Handshake: a request (cpl_req_o / wr_req_o) rises with its payload, holds both
  // stable until the matching ack is sampled high at a clock edge, and drops on the
  // following cycle; an ack sampled while its request is low has no effect.

  logic [2:0]  state_q, state_d;
  logic [63:0] cmd_q, cmd_d;
  logic [18:0] rem_q, rem_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  cmd_id_q, cmd_id_d;
  logic        cpl_req_q, cpl_req_d;
  logic        wr_req_q, wr_req_d;

  logic        fifo_rd_en;
  logic [1:0]  cmd_type;
  logic [4:0]  cmd_len;
  logic [1:0]  cmd_id_f;
  logic [54:0] cmd_payload;
  logic        is_cpl;
  logic        is_wr;
  logic [4:0]  eff_len;
  logic [18:0] init_rem;
  logic [9:0]  tlp_len;
  logic        unused_dout_hi;

  assign unused_dout_hi = ^us_cmd_fifo_dout_i[127:64];

  assign cmd_type    = cmd_q[63:62];
  assign cmd_len     = cmd_q[61:57];
  assign cmd_id_f    = cmd_q[56:55];
  assign cmd_payload = cmd_q[54:0];

  assign is_cpl = (cmd_type == `US_CMD_CPL_TYPE) || (cmd_type == `US_CMD_CPLD_TYPE);
  assign is_wr  = (cmd_type == `US_CMD_WR32_TYPE);

  // Gated by rst_n so nothing is popped while reset is held.
  assign fifo_rd_en = rst_n && (state_q == S_IDLE) && !us_cmd_fifo_empty_i;

  // Effective length is clamped to 2..20, giving 1 .. 2^18 DW in total.
  assign eff_len  = (cmd_len < 5'd2) ? 5'd2 : ((cmd_len > 5'd20) ? 5'd20 : cmd_len);
  assign init_rem = 19'd1 << (eff_len - 5'd2);

  assign tlp_len = (rem_q > {9'd0, MAX_DW}) ? MAX_DW : rem_q[9:0];

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    rem_d    = rem_q;
    addr_d   = addr_q;
    cmd_id_d = cmd_id_q;

    if (fifo_rd_en) begin
      cmd_d = us_cmd_fifo_dout_i[63:0];
    end

    case (state_q)
      S_IDLE: begin
        if (fifo_rd_en) begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_cpl) begin
          state_d = S_CPL;
        end else if (is_wr) begin
          state_d  = S_WR;
          rem_d    = init_rem;
          addr_d   = {cmd_payload[31:2], 2'b00};
          cmd_id_d = cmd_id_f;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CPL: begin
        if (cpl_ack_i) begin
          state_d = S_IDLE;
        end
      end
      S_WR: begin
        if (wr_ack_i) begin
          rem_d   = rem_q - {9'd0, tlp_len};
          addr_d  = addr_q + {20'd0, tlp_len, 2'b00};
          state_d = S_WR_NEXT;
        end
      end
      S_WR_NEXT: begin
        state_d = (rem_q != 19'd0) ? S_WR : S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    cpl_req_d = (state_d == S_CPL);
    wr_req_d  = (state_d == S_WR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cmd_q     <= '0;
      rem_q     <= '0;
      addr_q    <= '0;
      cmd_id_q  <= '0;
      cpl_req_q <= 1'b0;
      wr_req_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      rem_q     <= rem_d;
      addr_q    <= addr_d;
      cmd_id_q  <= cmd_id_d;
      cpl_req_q <= cpl_req_d;
      wr_req_q  <= wr_req_d;
    end
  end

  assign us_cmd_fifo_rd_en_o = fifo_rd_en;
  assign cpl_req_o           = cpl_req_q;
  assign cpl_with_data_o     = cpl_req_q && (cmd_type == `US_CMD_CPLD_TYPE);
  assign cpl_fields_o        = cmd_payload;
  assign wr_req_o            = wr_req_q;
  assign wr_addr_o           = addr_q;
  assign wr_len_dw_o         = tlp_len;
  assign up_wr_cmd_compl_o   = (state_q == S_DONE);
  assign cmd_id_o            = cmd_id_q;
  assign bad_cmd_o           = (state_q == S_DECODE) && !is_cpl && !is_wr;
  assign busy_o              = (state_q != S_IDLE);

endmodule

// File: tb/tb_us_cmd_sched.sv
// Bench for us_cmd_sched: FWFT FIFO model, randomised ack responder and an
// in-order scoreboard of completions, TLPs, done and bad-command events.

module tb_us_cmd_sched;

  localparam int W = 128;
  localparam logic [1:0] T_CPL  = 2'b00;
  localparam logic [1:0] T_CPLD = 2'b01;
  localparam logic [1:0] T_WR   = 2'b10;
  localparam logic [1:0] T_BAD  = 2'b11;
  localparam logic [3:0] K_CPL  = 4'd1;
  localparam logic [3:0] K_WR   = 4'd2;
  localparam logic [3:0] K_DONE = 4'd3;
  localparam logic [3:0] K_BAD  = 4'd4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] fifo_dout;
  logic         fifo_empty;
  logic         rd_en;
  logic         cpl_req;
  logic         cpl_with_data;
  logic [54:0]  cpl_fields;
  logic         cpl_ack = 1'b0;
  logic         wr_req;
  logic [31:0]  wr_addr;
  logic [9:0]   wr_len;
  logic         wr_ack = 1'b0;
  logic         compl;
  logic [1:0]   cmd_id;
  logic         bad;
  logic         busy;
  logic [105:0] all_outs;

  logic [127:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int fixed_wait = -1;
  bit stray_en = 1'b0;
  int wr_acc_cnt = 0;

  us_cmd_sched #(.MAX_PAYLOAD_DW(32)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .us_cmd_fifo_dout_i  (fifo_dout),
    .us_cmd_fifo_empty_i (fifo_empty),
    .us_cmd_fifo_rd_en_o (rd_en),
    .cpl_req_o           (cpl_req),
    .cpl_with_data_o     (cpl_with_data),
    .cpl_fields_o        (cpl_fields),
    .cpl_ack_i           (cpl_ack),
    .wr_req_o            (wr_req),
    .wr_addr_o           (wr_addr),
    .wr_len_dw_o         (wr_len),
    .wr_ack_i            (wr_ack),
    .up_wr_cmd_compl_o   (compl),
    .cmd_id_o            (cmd_id),
    .bad_cmd_o           (bad),
    .busy_o              (busy)
  );

  assign all_outs = {rd_en, cpl_req, cpl_with_data, cpl_fields, wr_req, wr_addr,
                     wr_len, compl, cmd_id, bad, busy};

  // ---------------- clock / reset ----------------
  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial begin
    #1_000_000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "bench did not finish");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic sb_pop_check(input string tag, input logic [W-1:0] got);
    if (exp_q.size() == 0) check({tag, "_unexpected"}, got, '0);
    else check(tag, got, exp_q.pop_front());
  endtask

  function automatic logic [W-1:0] e_cpl(input logic wd, input logic [54:0] f);
    return {K_CPL, 68'd0, wd, f};
  endfunction
  function automatic logic [W-1:0] e_wr(input logic [9:0] n, input logic [31:0] a);
    return {K_WR, 82'd0, n, a};
  endfunction
  function automatic logic [W-1:0] e_done(input logic [1:0] id, input logic [31:0] a);
    return {K_DONE, 90'd0, id, a};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic fifo_refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_dout  = fifo_empty ? '0 : fifo_q[0];
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [1:0] t, input logic [4:0] len,
                          input logic [1:0] id, input logic [54:0] pl);
    logic [127:0] w;
    int           l;
    logic [18:0]  rem;
    logic [31:0]  a;
    logic [9:0]   n;
    w = {$urandom, $urandom, t, len, id, pl};
    fifo_q.push_back(w);
    fifo_refresh();
    case (t)
      T_CPL, T_CPLD: exp_q.push_back(e_cpl(t == T_CPLD, pl));
      T_WR: begin
        l = (len < 2) ? 2 : ((len > 20) ? 20 : int'(len));
        rem = 19'd1 << (l - 2);
        a = {pl[31:2], 2'b00};
        while (rem != 0) begin
          n = (rem > 19'd32) ? 10'd32 : rem[9:0];
          exp_q.push_back(e_wr(n, a));
          a = a + {20'd0, n, 2'b00};
          rem = rem - {9'd0, n};
        end
        exp_q.push_back(e_done(id, a));
      end
      default: exp_q.push_back({K_BAD, 124'd0});
    endcase
  endtask

  task automatic drain(input int budget, input string tag);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0 || busy) && i < budget) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_drain"}, W'(exp_q.size() != 0 || fifo_q.size() != 0 || busy), '0);
  endtask

  // ---------------- FIFO model, responder and monitor ----------------
  bit          pop_pending = 1'b0;
  bit          prev_rd_en = 1'b0;
  bit          last_pop_bad = 1'b0;
  int          last_pop_cyc = -100;
  bit          first_req_pending = 1'b0;
  bit          drop_pending = 1'b0;
  int          age = 0;
  int          cur_wait = 0;
  logic [99:0] snap;
  logic [99:0] cur_pl;

  initial begin
    fifo_refresh();
    forever begin
      @(negedge clk);
      if (pop_pending) begin
        void'(fifo_q.pop_front());
        fifo_refresh();
        pop_pending = 1'b0;
      end
      if (!rst_n) begin
        cpl_ack = 1'b0;
        wr_ack = 1'b0;
        age = 0;
        prev_rd_en = 1'b0;
        drop_pending = 1'b0;
        continue;
      end
      if (rd_en) begin
        check("rd_en_one_cycle", W'(prev_rd_en), '0);
        check("rd_en_while_busy", W'(busy), '0);
        if (last_pop_bad) check("pop_after_bad", W'(cyc - last_pop_cyc), W'(2));
        last_pop_bad = (fifo_dout[63:62] == T_BAD) && (fifo_q.size() >= 2);
        last_pop_cyc = cyc;
        first_req_pending = 1'b1;
        pop_pending = 1'b1;
      end
      prev_rd_en = rd_en;

      if (drop_pending) begin
        check("req_drop_after_ack", W'(cpl_req | wr_req), '0);
        drop_pending = 1'b0;
      end

      if (cpl_req || wr_req) begin
        check("req_mutex", W'(cpl_req & wr_req), '0);
        if (first_req_pending) begin
          check("req_latency", W'(cyc - last_pop_cyc), W'(2));
          first_req_pending = 1'b0;
        end
        cur_pl = {cpl_req, wr_req, cpl_with_data, cpl_fields, wr_len, wr_addr};
        if (age == 0) begin
          snap = cur_pl;
          cur_wait = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 2));
        end else begin
          check("req_stable", W'(cur_pl), W'(snap));
        end
        if (wr_req) check("len_nonzero", W'(wr_len != 10'd0), W'(1));
        if (age >= cur_wait) begin
          cpl_ack = cpl_req;
          wr_ack = wr_req;
          if (cpl_req) sb_pop_check("cpl_txn", e_cpl(cpl_with_data, cpl_fields));
          else begin
            sb_pop_check("wr_txn", e_wr(wr_len, wr_addr));
            wr_acc_cnt++;
          end
          age = 0;
          drop_pending = 1'b1;
        end else begin
          cpl_ack = 1'b0;
          // A wrong-channel ack must not retire the pending request.
          wr_ack = (stray_en && cpl_req) ? 1'($urandom_range(0, 1)) : 1'b0;
          cpl_ack = (stray_en && wr_req) ? 1'($urandom_range(0, 1)) : 1'b0;
          age++;
        end
      end else begin
        if (age > 0) check("req_hold", W'(0), W'(1));
        age = 0;
        cpl_ack = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
        wr_ack  = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
      end

      if (bad) sb_pop_check("bad_evt", {K_BAD, 124'd0});
      if (compl) sb_pop_check("done_evt", e_done(cmd_id, wr_addr));
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int i;
    int base_cnt;
    repeat (3) @(negedge clk);
    check("rst_outs", W'(all_outs), '0);
    push_cmd(T_CPLD, 5'd3, 2'd0, 55'h12345678ABCDE);
    @(negedge clk);
    check("rst_no_pop", W'(rd_en), '0);
    sync();
    rst_n = 1'b1;
    drain(200, "cpld");

    sync();
    push_cmd(T_CPL, 5'($urandom), 2'($urandom), {$urandom, 23'($urandom)});
    drain(200, "cpl");

    sync();
    push_cmd(T_WR, 5'd9, 2'd1, {23'($urandom), 32'h0000_1000});
    drain(500, "wr_len9");
    check("cmd_id_after_wr9", W'(cmd_id), W'(1));

    sync();
    push_cmd(T_WR, 5'd0, 2'd2, {23'($urandom), 32'h0000_2003});
    drain(200, "wr_len0");

    sync();
    push_cmd(T_BAD, 5'($urandom), 2'd3, {$urandom, 23'($urandom)});
    push_cmd(T_CPLD, 5'($urandom), 2'd1, {$urandom, 23'($urandom)});
    drain(200, "bad_then_cpld");
    check("cmd_id_hold", W'(cmd_id), W'(2));

    sync();
    push_cmd(T_WR, 5'd6, 2'd3, {23'd0, 32'hFFFF_FFF0});
    drain(200, "wr_wrap");

    for (int k = 0; k < 4; k++) begin
      sync();
      push_cmd(T_WR, 5'($urandom_range(0, 8)), 2'($urandom), {23'($urandom), $urandom});
      drain(800, "wr_rand");
    end

    sync();
    fixed_wait = 50;
    stray_en = 1'b1;
    push_cmd(T_WR, 5'd3, 2'd0, {23'd0, 32'h0000_3000});
    push_cmd(T_CPL, 5'd0, 2'd2, {$urandom, 23'($urandom)});
    drain(1000, "stall");
    stray_en = 1'b0;

    sync();
    fixed_wait = 0;
    push_cmd(T_WR, 5'd25, 2'd0, {23'd0, 32'h0001_0000});
    drain(40000, "wr_len25");
    fixed_wait = -1;

    sync();
    base_cnt = wr_acc_cnt;
    push_cmd(T_WR, 5'd9, 2'd2, {23'd0, 32'h0000_4000});
    push_cmd(T_CPLD, 5'd0, 2'd3, {$urandom, 23'($urandom)});
    i = 0;
    while (wr_acc_cnt == base_cnt && i < 200) begin
      @(negedge clk);
      i++;
    end
    check("rst_first_tlp", W'(wr_acc_cnt - base_cnt), W'(1));
    fixed_wait = 1000;
    i = 0;
    while (!wr_req && i < 50) begin
      @(negedge clk);
      i++;
    end
    check("rst_second_tlp_req", W'(wr_req), W'(1));
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_outs", W'(all_outs), '0);
    repeat (4) void'(exp_q.pop_front());
    repeat (3) begin
      @(negedge clk);
      check("rst_hold_outs", W'(all_outs), '0);
    end
    fixed_wait = -1;
    sync();
    rst_n = 1'b1;
    drain(200, "after_reset");
    check("cmd_id_after_reset", W'(cmd_id), '0);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
